// File: rtl/nebula_pkg.sv
// Project-wide defaults shared by NoC blocks; instantiating blocks pass these into
// parameterised primitives such as nebula_fifo.
package nebula_pkg;

  localparam int unsigned NebulaFlitWidth = 32;
  localparam int unsigned NebulaFifoDepth = 8;

endpackage : nebula_pkg

// File: rtl/nebula_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty, programmable almost flags
// and an occupancy count. Storage is not reset; only pointers and count are.
module nebula_fifo
  import nebula_pkg::*;
#(
  parameter int unsigned DATA_WIDTH          = NebulaFlitWidth,
  parameter int unsigned DEPTH               = NebulaFifoDepth,
  parameter int unsigned ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  wr_fire, rd_fire;

  assign full         = (count_q == CntW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (32'(count_q) >= ALMOST_FULL_THRESH);
  assign almost_empty = (32'(count_q) <= ALMOST_EMPTY_THRESH);
  assign count        = count_q;
  assign rd_data      = mem_q[rd_ptr_q];

  // A full FIFO drops the write even when a read frees a slot in the same cycle.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap so non-power-of-two depths work.
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule : nebula_fifo

// File: tb/tb_nebula_fifo.sv
// Directed self-checking bench for nebula_fifo at DEPTH=8, DATA_WIDTH=32.
// Inputs change and outputs are sampled on the falling edge.
module tb_nebula_fifo;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        empty;
  logic        almost_empty;
  logic [3:0]  count;

  int n_cmp;
  int n_fail;

  nebula_fifo #(
    .DATA_WIDTH          (32),
    .DEPTH               (8),
    .ALMOST_FULL_THRESH  (6),
    .ALMOST_EMPTY_THRESH (2)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus from a falling edge, return at the next falling edge.
  task automatic step(input logic we, input logic [31:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty: got %b want 1", empty);
    end
    n_cmp++;
    if (full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %b want 0", full);
    end
    n_cmp++;
    if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_almost: got ae=%b af=%b want ae=1 af=0",
                         almost_empty, almost_full);
    end
    n_cmp++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", count);
    end
  endtask

  task automatic test_single();
    step(1'b1, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (count !== 4'd1 || empty !== 1'b0) begin
      n_fail++; $display("FAIL single_wr_state: got count=%0d empty=%b want 1/0", count, empty);
    end
    n_cmp++;
    if (rd_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_fwft: got %h want deadbeef", rd_data);
    end
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL single_pop: got count=%0d empty=%b want 0/1", count, empty);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) step(1'b1, 32'(100 + i), 1'b0);
    n_cmp++;
    if (full !== 1'b1 || count !== 4'd8) begin
      n_fail++; $display("FAIL fill_full: got full=%b count=%0d want 1/8", full, count);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd_data !== 32'(100 + i)) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %0d want %0d", i, rd_data, 100 + i);
      end
      step(1'b0, 32'h0, 1'b1);
    end
    n_cmp++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", empty, count);
    end
  endtask

  task automatic test_flags();
    logic ae_exp, af_exp;
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 32'(200 + n), 1'b0);
      ae_exp = (n <= 2);
      af_exp = (n >= 6);
      n_cmp++;
      if (almost_empty !== ae_exp || almost_full !== af_exp || full !== (n == 8)
          || count !== 4'(n)) begin
        n_fail++;
        $display("FAIL flags_at_%0d: got ae=%b af=%b full=%b count=%0d want ae=%b af=%b full=%b",
                 n, almost_empty, almost_full, full, count, ae_exp, af_exp, n == 8);
      end
    end
    // Full with simultaneous write and read: only the read happens.
    step(1'b1, 32'h1234_5678, 1'b1);
    n_cmp++;
    if (count !== 4'd7 || full !== 1'b0 || rd_data !== 32'd202) begin
      n_fail++; $display("FAIL full_wr_rd: got count=%0d full=%b head=%0d want 7/0/202",
                         count, full, rd_data);
    end
    do_reset();
  endtask

  task automatic test_simul();
    step(1'b1, 32'd300, 1'b0);
    step(1'b1, 32'd301, 1'b0);
    step(1'b1, 32'd302, 1'b0);
    n_cmp++;
    if (rd_data !== 32'd300) begin
      n_fail++; $display("FAIL simul_head: got %0d want 300", rd_data);
    end
    step(1'b1, 32'hCAFEBABE, 1'b1);
    n_cmp++;
    if (count !== 4'd3) begin
      n_fail++; $display("FAIL simul_count: got %0d want 3", count);
    end
    n_cmp++;
    if (rd_data !== 32'd301) begin
      n_fail++; $display("FAIL simul_pop1: got %h want 301", rd_data);
    end
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (rd_data !== 32'd302) begin
      n_fail++; $display("FAIL simul_pop2: got %h want 302", rd_data);
    end
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (rd_data !== 32'hCAFEBABE || count !== 4'd1) begin
      n_fail++; $display("FAIL simul_pop3: got %h count=%0d want cafebabe/1", rd_data, count);
    end
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL simul_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_over_under();
    for (int i = 0; i < 8; i++) step(1'b1, 32'(400 + i), 1'b0);
    step(1'b1, 32'hDEADDEAD, 1'b0);
    n_cmp++;
    if (count !== 4'd8 || full !== 1'b1) begin
      n_fail++; $display("FAIL overflow_count: got %0d full=%b want 8/1", count, full);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rd_data !== 32'(400 + i)) begin
        n_fail++; $display("FAIL overflow_data[%0d]: got %h want %0d", i, rd_data, 400 + i);
      end
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL underflow: got count=%0d empty=%b want 0/1", count, empty);
    end
    // Empty with simultaneous write and read: only the write happens.
    step(1'b1, 32'h0BAD_F00D, 1'b1);
    n_cmp++;
    if (count !== 4'd1 || rd_data !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL empty_wr_rd: got count=%0d head=%h want 1/0badf00d",
                         count, rd_data);
    end
    step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_patterns();
    logic [31:0] pats [4];
    pats[0] = 32'h0000_0000;
    pats[1] = 32'hFFFF_FFFF;
    pats[2] = 32'hAAAA_AAAA;
    pats[3] = 32'h5555_5555;
    for (int i = 0; i < 4; i++) step(1'b1, pats[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data !== pats[i]) begin
        n_fail++; $display("FAIL pattern[%0d]: got %h want %h", i, rd_data, pats[i]);
      end
      step(1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'd500, 1'b0);
    step(1'b1, 32'd501, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: got count=%0d empty=%b want 0/1", count, empty);
    end
    step(1'b1, 32'd600, 1'b0);
    n_cmp++;
    if (rd_data !== 32'd600 || count !== 4'd1) begin
      n_fail++; $display("FAIL reset_mid_reuse: got %0d count=%0d want 600/1", rd_data, count);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_drain();
    test_flags();
    test_simul();
    test_over_under();
    test_patterns();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_nebula_fifo
